// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg: shared UART receive constants and FSM state type.
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int FRAME_LEN_1STOP = 11;
   localparam int FRAME_LEN_2STOP = 12;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP1  = 3'd4;
   localparam logic [2:0] ST_STOP2  = 3'd5;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP1  = ST_STOP1,
      STOP2  = ST_STOP2
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_datapath.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_datapath: shift register, parity/stop checks, output regs.
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx_datapath
   import uart_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rx_bit,
   input  logic                      parity_sel,
   input  logic                      shift_en,
   input  logic                      parity_en,
   input  logic                      stop_en,
   input  logic                      done,
   output logic [UART_DATA_BITS-1:0] data_out,
   output logic                      valid_out,
   output logic                      parity_err,
   output logic                      frame_err
);

   logic [UART_DATA_BITS-1:0] shreg;
   logic                      parity_bad;
   logic                      stop_bad;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg      <= '0;
         parity_bad <= 1'b0;
         stop_bad   <= 1'b0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         valid_out <= done;
         if (shift_en)
            shreg <= {rx_bit, shreg[UART_DATA_BITS-1:1]};
         // Parity sample also clears the stop accumulator for this frame.
         if (parity_en) begin
            parity_bad <= (^shreg) ^ rx_bit ^ parity_sel;
            stop_bad   <= 1'b0;
         end
         if (stop_en)
            stop_bad <= stop_bad | ~rx_bit;
         if (done) begin
            data_out   <= shreg;
            parity_err <= parity_bad;
            frame_err  <= stop_bad | ~rx_bit;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_top_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_top_rx: UART receiver - synchronizer, bit timer and FSM.
// Rev 1.0
// ------------------------------------------------------------------
module uart_top_rx
   import uart_pkg::*;
#(
   parameter int DIV_W = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rx,
   input  logic                      parity_sel,
   input  logic                      stop_sel,
   input  logic [DIV_W-1:0]          baud_divisor,
   output logic [UART_DATA_BITS-1:0] data_out,
   output logic                      valid_out,
   output logic                      parity_err,
   output logic                      frame_err
);

   logic             sync1;
   logic             rx_s;
   logic             rx_prev;
   rx_state_t        state;
   logic [DIV_W-1:0] timer;
   logic [DIV_W-1:0] div_l;
   logic             psel_l;
   logic             ssel_l;
   logic [2:0]       bit_cnt;
   logic             tick;
   logic             fall;
   logic             shift_en;
   logic             parity_en;
   logic             stop_en;
   logic             done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   // rx_prev must see a 1 first, so a line held low after a break never re-triggers.
   assign fall = rx_prev & ~rx_s;
   assign tick = (state != IDLE) && (timer == DIV_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         timer   <= '0;
         div_l   <= '0;
         psel_l  <= 1'b0;
         ssel_l  <= 1'b0;
         bit_cnt <= 3'd0;
      end else if (state == IDLE) begin
         if (fall) begin
            timer  <= baud_divisor >> 1;
            div_l  <= baud_divisor;
            psel_l <= parity_sel;
            ssel_l <= stop_sel;
            state  <= START;
         end
      end else if (tick) begin
         timer <= div_l;
         case (state)
            START: begin
               if (rx_s) begin
                  state <= IDLE;
               end else begin
                  state   <= DATA;
                  bit_cnt <= 3'd0;
               end
            end
            DATA: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state <= PARITY;
            end
            PARITY:  state <= STOP1;
            STOP1:   state <= ssel_l ? STOP2 : IDLE;
            default: state <= IDLE;
         endcase
      end else if (timer != '0) begin
         timer <= timer - DIV_W'(1);
      end
   end

   assign shift_en  = tick && (state == DATA);
   assign parity_en = tick && (state == PARITY);
   assign stop_en   = tick && ((state == STOP1) || (state == STOP2));
   assign done      = tick && (((state == STOP1) && !ssel_l) || (state == STOP2));

   uart_rx_datapath u_datapath (
      .clk        (clk),
      .reset      (reset),
      .rx_bit     (rx_s),
      .parity_sel (psel_l),
      .shift_en   (shift_en),
      .parity_en  (parity_en),
      .stop_en    (stop_en),
      .done       (done),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

endmodule
`default_nettype wire
